fifo_wr_arb: RTL
================

# fifo_wr_arb

Write-side arbiter that shares one `fifo` write port among `NUM_REQ` producers. Each producer has a valid/ready handshake. The block grants the FIFO to one producer at a time in round-robin order and holds each grant for a bounded burst. It forwards the owner's data to `wdata_i`/`wr_en_i` of the FIFO and honours `full_o` backpressure. It sits directly in front of the FIFO write port; the FIFO read side is untouched.

## Interface
Parameters:
- `NUM_REQ`, 4: number of producers, 2..16.
- `WIDTH`, 32: data width; must equal the FIFO `WIDTH`.
- `BURST`, 4: maximum beats per grant, 1..255.

Ports:
- `clk_i`  in  1  clock, all logic on the rising edge.
- `rst_n_i`  in  1  asynchronous active-low reset.
- `req_valid_i`  in  `NUM_REQ`  producer has a word.
- `req_data_i`  in  `NUM_REQ`×`WIDTH`  producer words, packed, requester k at `[k*WIDTH +: WIDTH]`.
- `req_ready_o`  out  `NUM_REQ`  word accepted this cycle when ANDed with valid.
- `fifo_wdata_o`  out  `WIDTH`  to FIFO `wdata_i`.
- `fifo_wr_en_o`  out  1  to FIFO `wr_en_i`.
- `fifo_full_i`  in  1  from FIFO `full_o`.
- `grant_valid_o`  out  1  a grant is held (state GRANT).
- `grant_id_o`  out  `$clog2(NUM_REQ)`  current or last owner index.

## Operation
States:
- IDLE: no owner.
  - If any `req_valid_i` bit is set, pick the first set index searching from `last_owner+1` with wrap.
  - Register the winner as owner, clear the beat count, go to GRANT.
  - If no bit is set, stay in IDLE.
- GRANT: outputs while in this state:
  - `req_ready_o[owner] = !fifo_full_i`; all other ready bits 0.
  - `fifo_wr_en_o = req_valid_i[owner] && !fifo_full_i`.
  - `fifo_wdata_o` = owner's word.
- Transfer: `fifo_wr_en_o` high. The beat count increments on each transfer.

Release (GRANT→IDLE, `last_owner` ← owner):
- A transfer makes the beat count equal `BURST`, or
- `req_valid_i[owner]` is 0 in a GRANT cycle. Full does not matter in this case.

Other rules:
- Full stall: the owner keeps the grant and the beat count holds. There is no timeout.
- Non-owner valids are ignored until the next IDLE arbitration.
- Producers must hold data stable while valid and not ready. The block does not check this.
- Outside GRANT: `req_ready_o` = 0, `fifo_wr_en_o` = 0, `fifo_wdata_o` = 0.

## Timing
- Reset values: state IDLE, `last_owner` = `NUM_REQ-1` (requester 0 has first priority), beat count 0, `grant_id_o` = `NUM_REQ-1`, `grant_valid_o` = 0. All other outputs are 0.
- Arbitration latency: a valid seen in IDLE at edge N gives GRANT and ready from cycle N+1. First possible FIFO write is at edge N+1.
- Ready, `wr_en` and `wdata` are combinational from state plus `fifo_full_i` and `req_*`. Nothing is registered on the data path.
- One mandatory IDLE cycle between grants. Saturated throughput is BURST/(BURST+1).
- Beat count width is 8 bits; it never exceeds `BURST`.
- If the last burst beat coincides with the owner dropping valid, release once. `last_owner` is unchanged by the double cause.
- Reset asserted mid-burst: immediate return to the reset values. Any in-flight beat is not written.
- The owner's valid and full rising in the same cycle: no transfer, grant held, count held.

## Structure
- Package `fifo_arb_pkg`: state enum `arb_state_t {ARB_IDLE, ARB_GRANT}`, beat-count width constant `ARB_CNT_W = 8`.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: request vector, last index.
  - Outputs: winner index, any-request flag.
  - Parameterised by `NUM_REQ`; reused by future read-side schedulers.
- Top holds the state register, owner/last_owner registers, beat counter and output muxes.

## Test plan
- Single producer: only req 2 valid, 6 words 0x10..0x15, `BURST`=4.
  - Expect grant to 2 for 4 beats, one IDLE cycle, re-grant to 2 for 2 beats.
  - FIFO read-back is 0x10..0x15 in order.
- Round-robin fairness: all 4 valid continuously, 3 bursts each.
  - Grant order 0,1,2,3,0,1,2,3,0,1,2,3 with 4 beats per grant and exactly 1 IDLE cycle between grants.
- Full backpressure: fill the 16-deep FIFO to 15 entries, owner streams 3 words.
  - Expect 1 write, then `full_o`.
  - Ready low and count held until one read.
  - The remaining 2 words are written after space frees; no word is lost or duplicated.
- Early release: req 1 asserts valid for 2 words, then drops.
  - Expect release after beat 2.
  - `last_owner`=1; a pending req 3 wins the next arbitration over req 0.
- Reset mid-burst: assert `rst_n_i`=0 after beat 2 of a grant to req 0.
  - Expect `fifo_wr_en_o`=0 and `grant_valid_o`=0 immediately.
  - After release, the first grant goes to req 0.
- Idle/no-write check: every cycle with `fifo_full_i`=1 or state IDLE must have `fifo_wr_en_o`=0. Run as a concurrent assertion throughout all tests.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-side arbiter and related schedulers.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  localparam int unsigned ARB_CNT_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last_i+1, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    last_i,
  output logic [IdxW-1:0]    win_o,
  output logic               any_o
);

  // Walk offsets from farthest to nearest so the nearest set request overwrites the rest.
  always_comb begin
    win_o = '0;
    any_o = 1'b0;
    for (int i = int'(NUM_REQ); i >= 1; i--) begin
      automatic int          idx = (int'(last_i) + i) % int'(NUM_REQ);
      automatic logic [IdxW-1:0] k = IdxW'(idx);
      if (req_i[k]) begin
        win_o = k;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write-port arbiter: grants the FIFO write port to one producer for up to BURST beats.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned BURST   = 4,
  localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic [WIDTH-1:0]         fifo_wdata_o,
  output logic                     fifo_wr_en_o,
  input  logic                     fifo_full_i,
  output logic                     grant_valid_o,
  output logic [IdxW-1:0]          grant_id_o
);

  localparam logic [ARB_CNT_W-1:0] BurstCnt = ARB_CNT_W'(BURST);
  localparam logic [IdxW-1:0]      LastRst  = IdxW'(NUM_REQ - 1);

  arb_state_t           state_q, state_d;
  logic [IdxW-1:0]      owner_q, owner_d;
  logic [IdxW-1:0]      last_q, last_d;
  logic [ARB_CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] req_word [NUM_REQ];
  logic [IdxW-1:0]  pick_win;
  logic             pick_any;
  logic             own_valid;
  logic             xfer;

  for (genvar g = 0; g < NUM_REQ; g++) begin : gen_unpack
    assign req_word[g] = req_data_i[g*WIDTH +: WIDTH];
  end

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req_i  (req_valid_i),
    .last_i (last_q),
    .win_o  (pick_win),
    .any_o  (pick_any)
  );

  assign own_valid = req_valid_i[owner_q];
  assign xfer      = own_valid && !fifo_full_i;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    req_ready_o  = '0;
    fifo_wr_en_o = 1'b0;
    fifo_wdata_o = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_GRANT;
          owner_d = pick_win;
          cnt_d   = '0;
        end
      end
      ARB_GRANT: begin
        req_ready_o[owner_q] = !fifo_full_i;
        fifo_wr_en_o         = xfer;
        fifo_wdata_o         = req_word[owner_q];
        // Owner dropping valid releases regardless of full; a full stall holds count and grant.
        if (!own_valid) begin
          state_d = ARB_IDLE;
          last_d  = owner_q;
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == BurstCnt) begin
            state_d = ARB_IDLE;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ARB_IDLE;
      owner_q <= LastRst;
      last_q  <= LastRst;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_valid_o = (state_q == ARB_GRANT);
  assign grant_id_o    = grant_valid_o ? owner_q : last_q;

endmodule
